// File: rtl/lcd_nn_scaler.sv
// Nearest-neighbour upscaler between an SDRAM read FIFO and an RGB565 LCD driver.
// Fill lines stream FIFO pixels into a line buffer; repeat lines replay that buffer.
module lcd_nn_scaler #(
  parameter int          BUF_AW       = 10,
  parameter logic [15:0] UNDERRUN_RGB = 16'h0000
) (
  input  logic        lcd_pclk,
  input  logic        rst_n,
  input  logic        lcd_vs,
  input  logic        data_req,
  input  logic        flush_req,
  output logic [15:0] pixel_data,
  output logic        fifo_rd_en,
  input  logic [15:0] fifo_rd_data,
  input  logic        fifo_empty,
  input  logic [10:0] src_h_disp,
  input  logic [2:0]  h_scale,
  input  logic [2:0]  v_scale,
  output logic        underrun,
  output logic        frame_active
);

  localparam int                MAX_W   = 1 << BUF_AW;
  localparam logic [BUF_AW-1:0] CNT_ONE = {{(BUF_AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, FILL, REPEAT} state_t;

  state_t            state;
  logic              vs_d;
  logic [BUF_AW-1:0] w_last;
  logic [1:0]        hs_last;
  logic [1:0]        vs_last;
  logic [BUF_AW-1:0] h_cnt;
  logic [1:0]        h_phase;
  logic [1:0]        v_phase;

  logic [15:0]       line_buf [MAX_W];
  logic [15:0]       pix_q;
  logic [15:0]       rd_q;
  logic [15:0]       wr_data_p1;
  logic [BUF_AW-1:0] wr_addr_p1;
  logic              wr_vld_p1;
  logic              wr_und_p1;
  logic              rd_vld_p1;

  logic              vs_rise;
  logic              req;
  logic              fill_req;
  logic              rep_rd;
  logic              line_end;

  // Line width stored as last index (1..2^BUF_AW pixels -> 0..2^BUF_AW-1).
  function automatic logic [BUF_AW-1:0] width_last(input logic [10:0] w);
    int n;
    n = int'(w);
    if (n < 1) n = 1;
    if (n > MAX_W) n = MAX_W;
    n = n - 1;
    return n[BUF_AW-1:0];
  endfunction

  function automatic logic [1:0] scale_last(input logic [2:0] s);
    logic [2:0] t;
    if (s == 3'd0)      t = 3'd1;
    else if (s > 3'd4)  t = 3'd4;
    else                t = s;
    t = t - 3'd1;
    return t[1:0];
  endfunction

  // A frame-start cycle swallows any pixel request so counters restart cleanly.
  assign vs_rise    = lcd_vs & ~vs_d;
  assign req        = data_req & ~vs_rise;
  assign fill_req   = req & (state == FILL) & (h_phase == 2'd0);
  assign rep_rd     = req & (state == REPEAT) & (h_phase == 2'd0);
  assign line_end   = (h_phase == hs_last) && (h_cnt == w_last);
  assign fifo_rd_en = ~fifo_empty & (fill_req | (flush_req & ~data_req));

  // Stage p1: FIFO word (or underrun fill) and buffer read both land here.
  assign wr_data_p1 = wr_und_p1 ? UNDERRUN_RGB : fifo_rd_data;
  assign pixel_data = wr_vld_p1 ? wr_data_p1 : (rd_vld_p1 ? rd_q : pix_q);

  always_ff @(posedge lcd_pclk) begin
    if (wr_vld_p1) line_buf[wr_addr_p1] <= wr_data_p1;
    // With a one-pixel line the replay read can hit the word being written.
    if (rep_rd) rd_q <= (wr_vld_p1 && (wr_addr_p1 == h_cnt)) ? wr_data_p1 : line_buf[h_cnt];
    if (fill_req) wr_addr_p1 <= h_cnt;
  end

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      vs_d         <= 1'b0;
      w_last       <= '0;
      hs_last      <= '0;
      vs_last      <= '0;
      h_cnt        <= '0;
      h_phase      <= '0;
      v_phase      <= '0;
      wr_vld_p1    <= 1'b0;
      wr_und_p1    <= 1'b0;
      rd_vld_p1    <= 1'b0;
      pix_q        <= '0;
      underrun     <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      vs_d      <= lcd_vs;
      wr_vld_p1 <= fill_req;
      wr_und_p1 <= fill_req & fifo_empty;
      rd_vld_p1 <= rep_rd;
      pix_q     <= pixel_data;
      if (fill_req && fifo_empty) underrun <= 1'b1;
      if (vs_rise) begin
        state        <= FILL;
        frame_active <= 1'b1;
        w_last       <= width_last(src_h_disp);
        hs_last      <= scale_last(h_scale);
        vs_last      <= scale_last(v_scale);
        h_cnt        <= '0;
        h_phase      <= '0;
        v_phase      <= '0;
      end else if (req) begin
        if (state == IDLE) begin
          pix_q <= UNDERRUN_RGB;
        end else if (line_end) begin
          h_cnt   <= '0;
          h_phase <= '0;
          if (v_phase == vs_last) begin
            v_phase <= '0;
            state   <= FILL;
          end else begin
            v_phase <= v_phase + 2'd1;
            state   <= REPEAT;
          end
        end else if (h_phase == hs_last) begin
          h_phase <= '0;
          h_cnt   <= h_cnt + CNT_ONE;
        end else begin
          h_phase <= h_phase + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_nn_scaler.sv
// Bench for lcd_nn_scaler: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a line/pixel-index model.
module tb_lcd_nn_scaler;

  localparam logic [15:0] UND = 16'h0000;

  logic        lcd_pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lcd_vs = 1'b0;
  logic        data_req = 1'b0;
  logic        flush_req = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_rd_data = 16'h0000;
  logic [10:0] src_h_disp = 11'd0;
  logic [2:0]  h_scale = 3'd0;
  logic [2:0]  v_scale = 3'd0;
  logic [15:0] pixel_data;
  logic        fifo_rd_en;
  logic        underrun;
  logic        frame_active;

  always #5 lcd_pclk = ~lcd_pclk;

  lcd_nn_scaler #(.BUF_AW(10), .UNDERRUN_RGB(UND)) dut (
    .lcd_pclk(lcd_pclk), .rst_n(rst_n), .lcd_vs(lcd_vs), .data_req(data_req),
    .flush_req(flush_req), .pixel_data(pixel_data), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .src_h_disp(src_h_disp),
    .h_scale(h_scale), .v_scale(v_scale), .underrun(underrun), .frame_active(frame_active)
  );

  int nvec = 0;
  int nerr = 0;
  int nrd = 0;
  logic [15:0] fq[$];
  logic [15:0] got[$];
  logic [15:0] exp_q[$];

  // Behavioural model: pixel k of output line L shows source pixel k/h of the
  // most recent fill line; fill lines are those with L % v == 0.
  bit          m_frame = 0;
  bit          m_und = 0;
  bit          vs_prev = 0;
  bit          prev_req = 0;
  int          m_w = 1, m_h = 1, m_v = 1, m_k = 0, m_line = 0;
  logic [15:0] m_buf[1024];
  logic [15:0] m_pix = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic chk_seq(input string name, input logic [15:0] e[$]);
    chk({name, "_len"}, got.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < got.size()) chk(name, got[i], e[i]);
  endtask

  function automatic int clampw(input int w);
    if (w == 0) return 1;
    if (w > 1024) return 1024;
    return w;
  endfunction

  function automatic int clamps(input int s);
    if (s == 0) return 1;
    if (s > 4) return 4;
    return s;
  endfunction

  // One clock cycle; entered and left just after a falling edge.
  task automatic step(input bit dr, input bit fl, input bit vs);
    bit vs_rise, empty, fill, ph0, exp_rd, rd_now;
    int idx;
    data_req = dr; flush_req = fl; lcd_vs = vs;
    empty = (fq.size() == 0);
    fifo_empty = empty;
    #1;
    vs_rise = vs && !vs_prev;
    fill = m_frame && ((m_line % m_v) == 0);
    ph0 = (m_k % m_h) == 0;
    exp_rd = !empty && ((dr && !vs_rise && m_frame && fill && ph0) || (!dr && fl));
    chk("fifo_rd_en", fifo_rd_en, exp_rd);
    chk("pixel_data", pixel_data, m_pix);
    chk("underrun", underrun, m_und);
    chk("frame_active", frame_active, m_frame);
    if (prev_req) got.push_back(pixel_data);
    if (vs_rise) begin
      m_frame = 1; m_k = 0; m_line = 0;
      m_w = clampw(int'(src_h_disp)); m_h = clamps(int'(h_scale)); m_v = clamps(int'(v_scale));
    end else if (dr) begin
      if (!m_frame) m_pix = UND;
      else begin
        idx = m_k / m_h;
        if (ph0) begin
          if (fill) begin
            if (empty) begin m_pix = UND; m_und = 1; end
            else m_pix = fq[0];
            m_buf[idx] = m_pix;
          end else m_pix = m_buf[idx];
        end
        m_k++;
        if (m_k == m_w * m_h) begin m_k = 0; m_line++; end
      end
    end
    vs_prev = vs;
    prev_req = dr && !vs_rise;
    rd_now = fifo_rd_en;
    if (rd_now) nrd++;
    @(posedge lcd_pclk);
    #1;
    if (rd_now && fq.size() > 0) fifo_rd_data = fq.pop_front();
    @(negedge lcd_pclk);
  endtask

  task automatic frame_start(input int w, input int h, input int v);
    src_h_disp = 11'(w); h_scale = 3'(h); v_scale = 3'(v);
    step(0, 0, 1);
    step(0, 0, 0);
    got.delete();
    nrd = 0;
  endtask

  task automatic mid_reset();
    data_req = 0; flush_req = 0; lcd_vs = 0;
    rst_n = 0;
    #1;
    chk("rst_pixel", pixel_data, 16'h0000);
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_frame_active", frame_active, 1'b0);
    m_frame = 0; m_und = 0; m_pix = 16'h0000; m_k = 0; m_line = 0;
    vs_prev = 0; prev_req = 0;
    @(negedge lcd_pclk);
    @(negedge lcd_pclk);
    rst_n = 1;
    got.delete();
    nrd = 0;
  endtask

  initial begin
    repeat (3) @(negedge lcd_pclk);
    chk("reset_pixel", pixel_data, 16'h0000);
    chk("reset_rd_en", fifo_rd_en, 1'b0);
    chk("reset_underrun", underrun, 1'b0);
    chk("reset_frame_active", frame_active, 1'b0);
    rst_n = 1;
    @(negedge lcd_pclk);

    // Plain pass-through, fill mode kept for the next line.
    fq = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    frame_start(4, 1, 1);
    repeat (4) step(1, 0, 0);
    step(0, 0, 0);
    exp_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    chk_seq("pass_pixels", exp_q);
    chk("pass_reads", nrd, 4);
    fq = '{16'h0005, 16'h0006};
    repeat (2) step(1, 0, 0);
    chk("next_line_reads", nrd, 6);

    // Horizontal x2.
    fq = '{16'hA0A0, 16'hB1B1, 16'hC2C2};
    frame_start(3, 2, 1);
    repeat (6) step(1, 0, 0);
    step(0, 0, 0);
    exp_q = '{16'hA0A0, 16'hA0A0, 16'hB1B1, 16'hB1B1, 16'hC2C2, 16'hC2C2};
    chk_seq("hx2_pixels", exp_q);
    chk("hx2_reads", nrd, 3);

    // Vertical x3: two replayed lines, then back to fill.
    fq = '{16'h1234, 16'h5678};
    frame_start(2, 1, 3);
    repeat (6) step(1, 0, 0);
    step(0, 0, 0);
    exp_q = '{16'h1234, 16'h5678, 16'h1234, 16'h5678, 16'h1234, 16'h5678};
    chk_seq("vx3_pixels", exp_q);
    chk("vx3_reads", nrd, 2);
    fq = '{16'h9ABC, 16'hDEF0};
    repeat (2) step(1, 0, 0);
    chk("vx3_refill_reads", nrd, 4);

    // Underrun on the second pixel.
    fq = '{16'h00AA};
    frame_start(3, 1, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    fq.push_back(16'h00CC);
    step(1, 0, 0);
    step(0, 0, 0);
    exp_q = '{16'h00AA, UND, 16'h00CC};
    chk_seq("underrun_pixels", exp_q);
    chk("underrun_reads", nrd, 2);
    chk("underrun_flag", underrun, 1'b1);
    frame_start(3, 1, 1);
    chk("underrun_sticky", underrun, 1'b1);

    // Flush drains without touching the output; data_req wins over flush.
    fq = '{16'h0D0D};
    frame_start(4, 1, 1);
    step(1, 0, 0);
    fq.push_back(16'h0E01); fq.push_back(16'h0E02); fq.push_back(16'h0E03);
    repeat (5) step(0, 1, 0);
    chk("flush_reads", nrd, 4);
    chk("flush_hold", pixel_data, 16'h0D0D);
    fq.push_back(16'h0F0F);
    step(1, 1, 0);
    step(0, 0, 0);
    chk("req_over_flush_reads", nrd, 5);
    chk("req_over_flush_pixel", pixel_data, 16'h0F0F);

    // Reset in the middle of a replay line.
    fq = '{16'h1111, 16'h2222};
    frame_start(2, 1, 3);
    repeat (3) step(1, 0, 0);
    mid_reset();
    fq = '{16'h3333, 16'h4444};
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    exp_q = '{UND, UND};
    chk_seq("post_reset_pixels", exp_q);
    chk("post_reset_reads", nrd, 0);
    fq.delete();

    // Randomized frames, including out-of-range configuration values.
    for (int it = 0; it < 40; it++) begin
      int n;
      frame_start($urandom_range(0, 12), $urandom_range(0, 7), $urandom_range(0, 7));
      n = $urandom_range(20, 120);
      for (int c = 0; c < n; c++) begin
        bit dr, fl;
        if (fq.size() < 4 && $urandom_range(0, 9) < 6) fq.push_back(16'($urandom));
        if ($urandom_range(0, 15) == 0) begin
          src_h_disp = 11'($urandom); h_scale = 3'($urandom); v_scale = 3'($urandom);
        end
        dr = ($urandom_range(0, 9) < 7);
        fl = ($urandom_range(0, 9) == 0);
        step(dr, fl, 0);
      end
      if (it == 17 || it == 31) mid_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lcd_nn_scaler.md
LCD_NN_SCALER -- requirements
Module: lcd_nn_scaler

Interface
REQ-001 SHALL have parameter BUF_AW, default 10, line-buffer address width (1024 source pixels max).
REQ-002 SHALL have parameter UNDERRUN_RGB, default 16'h0000, pixel emitted on FIFO underrun.
REQ-003 SHALL have ports:
- lcd_pclk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- lcd_vs  in  1  frame sync from LCD timing; rising edge marks frame start
- data_req  in  1  pixel request from LCD driver
- flush_req  in  1  tail-flush request (frame padding not burst-aligned)
- pixel_data  out  16  RGB565 pixel to LCD driver
- fifo_rd_en  out  1  read strobe to SDRAM read FIFO (normal mode, data one cycle later)
- fifo_rd_data  in  16  FIFO read data
- fifo_empty  in  1  FIFO empty flag
- src_h_disp  in  11  source line width, pixels
- h_scale  in  3  horizontal repeat factor
- v_scale  in  3  vertical repeat factor
- underrun  out  1  sticky underrun flag
- frame_active  out  1  high while a frame is being scaled

Function
REQ-004 SHALL sample src_h_disp, h_scale and v_scale on each lcd_vs rising edge; values 0 are treated as 1, values >4 as 4; src_h_disp >2^BUF_AW is clamped to 2^BUF_AW.
REQ-005 SHALL implement states IDLE, FILL, REPEAT; reset -> IDLE; lcd_vs rising edge from any state -> FILL with h_cnt=0, h_phase=0, v_phase=0.
REQ-006 Per output line SHALL count src_h_disp*h_scale accepted data_req cycles (12-bit product); the count is not limited by the position of data_req within the line.
REQ-007 In FILL, data_req with h_phase==0 SHALL assert fifo_rd_en combinationally in the same cycle when fifo_empty=0.
REQ-008 The FIFO word read in cycle T SHALL appear on pixel_data in T+1 and be written into line-buffer address h_cnt in T+1.
REQ-009 In REPEAT, data_req with h_phase==0 SHALL read line-buffer address h_cnt (synchronous read), and the data SHALL appear on pixel_data in T+1.
REQ-010 For data_req with h_phase!=0, pixel_data in T+1 SHALL repeat the previous pixel; h_phase wraps at h_scale-1, and h_cnt then increments.
REQ-011 pixel_data SHALL hold its last value in cycles without a preceding data_req.
REQ-012 At end of line (last count of REQ-006) SHALL clear h_cnt/h_phase, increment v_phase, and go to REPEAT if v_phase<v_scale-1; on wrap go to FILL.
REQ-013 FILL with data_req, h_phase==0 and fifo_empty=1 SHALL keep fifo_rd_en low, output UNDERRUN_RGB in T+1, write UNDERRUN_RGB to the buffer, advance counters normally and set underrun.
REQ-014 flush_req SHALL assert fifo_rd_en whenever fifo_empty=0, discard the returned data, and leave counters, buffer and pixel_data unchanged.
REQ-015 If data_req and flush_req are both high, data_req SHALL take priority; flush is ignored in that cycle.
REQ-016 data_req in IDLE SHALL output UNDERRUN_RGB and set neither fifo_rd_en nor underrun.
REQ-017 frame_active SHALL be 1 in FILL/REPEAT and 0 in IDLE.
REQ-018 fifo_rd_en SHALL never be high while fifo_empty=1.

Reset
REQ-019 While rst_n=0: state IDLE, pixel_data=16'h0000, fifo_rd_en=0, underrun=0, frame_active=0, all counters 0; buffer contents are undefined.
REQ-020 underrun SHALL clear only on reset; a reset mid-line aborts the frame, and output resumes at the next lcd_vs rising edge.

Verification
REQ-021 src_h_disp=4, h_scale=1, v_scale=1, FIFO holds 1,2,3,4, 4 data_req -> fifo_rd_en on each req, pixel_data 1,2,3,4 one cycle later, FILL retained for the next line.
REQ-022 src_h_disp=3, h_scale=2, FIFO A,B,C -> 3 FIFO reads, pixel_data A,A,B,B,C,C.
REQ-023 src_h_disp=2, h_scale=1, v_scale=3, FIFO P,Q -> line0 reads FIFO; lines 1-2 output P,Q with no fifo_rd_en; line 3 returns to FILL.
REQ-024 FIFO empty during the 2nd FILL request -> pixel 2 = 16'h0000, underrun=1, counters advance, pixel 3 fetched normally; underrun stays high after the next lcd_vs.
REQ-025 flush_req high for 5 cycles with 3 FIFO words -> exactly 3 fifo_rd_en pulses, pixel_data unchanged; flush_req and data_req high together -> a single read, consumed as pixel.
REQ-026 rst_n pulsed low mid-REPEAT -> all outputs 0 asynchronously; data_req before the next lcd_vs edge -> 16'h0000, no reads.
